// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, timing/colour structs and
// the 3-3-2 to 8-8-8 colour expansion.
package vga_pkg;

    localparam int H_ACT_DEF = 640;
    localparam int H_FP_DEF  = 16;
    localparam int H_SYN_DEF = 96;
    localparam int H_BP_DEF  = 48;
    localparam int V_ACT_DEF = 480;
    localparam int V_FP_DEF  = 10;
    localparam int V_SYN_DEF = 2;
    localparam int V_BP_DEF  = 33;

    typedef struct packed {
        logic [15:0] act;
        logic [15:0] fp;
        logic [15:0] syn;
        logic [15:0] bp;
    } timing_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Per-pixel control travelling down the scanout pipeline; all-zero = idle/reset.
    typedef struct packed {
        logic act;
        logic grid;
        logic hs;
        logic vs;
    } pix_ctl_t;

    function automatic int tim_total(timing_t t);
        return int'(t.act) + int'(t.fp) + int'(t.syn) + int'(t.bp);
    endfunction

    function automatic rgb_t expand332(logic [7:0] c);
        rgb_t p;
        p.r = {c[7:5], c[7:5], c[7:6]};
        p.g = {c[4:2], c[4:2], c[4:3]};
        p.b = {4{c[1:0]}};
        return p;
    endfunction

endpackage

// File: rtl/video_ram_dp.sv
// Cell memory: one synchronous write port, a CPU read port and an enabled
// scanout read port. Reads return pre-write data on an address collision.
module video_ram_dp #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              sen,
    input  logic [AW-1:0]     saddr,
    output logic [DATA_W-1:0] sdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && int'(waddr) < DEPTH)
            mem[waddr] <= wdata;
    end

    // Contents are never cleared; only the read registers see reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
            sdata <= '0;
        end else begin
            rdata <= (int'(raddr) < DEPTH) ? mem[raddr] : '0;
            if (sen)
                sdata <= (int'(saddr) < DEPTH) ? mem[saddr] : '0;
        end
    end

endmodule

// File: rtl/vga_tile_display.sv
// Tile-mapped VGA scanout: pixel divider, h/v timing, incremental cell
// addressing and a 2-stage (address, memory read) pixel pipeline.
module vga_tile_display
    import vga_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CELLS_X = 8,
    parameter int CELLS_Y = 8,
    parameter int CELL_PX = 60,
    parameter int CLK_DIV = 2,
    parameter int H_ACT   = H_ACT_DEF,
    parameter int H_FP    = H_FP_DEF,
    parameter int H_SYN   = H_SYN_DEF,
    parameter int H_BP    = H_BP_DEF,
    parameter int V_ACT   = V_ACT_DEF,
    parameter int V_FP    = V_FP_DEF,
    parameter int V_SYN   = V_SYN_DEF,
    parameter int V_BP    = V_BP_DEF,
    parameter logic [DATA_W-1:0] BORDER = '0,
    localparam int DEPTH  = CELLS_X * CELLS_Y,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata,
    output logic [7:0]        R,
    output logic [7:0]        G,
    output logic [7:0]        B,
    output logic              hsync,
    output logic              vsync,
    output logic              vgaclk,
    output logic              frame_start
);

    localparam timing_t H_T = '{act: 16'(H_ACT), fp: 16'(H_FP), syn: 16'(H_SYN), bp: 16'(H_BP)};
    localparam timing_t V_T = '{act: 16'(V_ACT), fp: 16'(V_FP), syn: 16'(V_SYN), bp: 16'(V_BP)};
    localparam int H_TOTAL = tim_total(H_T);
    localparam int V_TOTAL = tim_total(V_T);
    localparam int HS_BEG  = int'(H_T.act) + int'(H_T.fp);
    localparam int HS_END  = HS_BEG + int'(H_T.syn);
    localparam int VS_BEG  = int'(V_T.act) + int'(V_T.fp);
    localparam int VS_END  = VS_BEG + int'(V_T.syn);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(CLK_DIV);
    localparam int CPW     = $clog2(CELL_PX + 1);
    localparam int RBW     = $clog2(V_TOTAL * CELLS_X + 1);
    localparam int AFW     = RBW + HW;
    localparam rgb_t BORDER_RGB = expand332(8'(BORDER));

    logic [DW-1:0]     div_cnt, div_next;
    logic              pix_en;
    logic [HW-1:0]     h_cnt, cell_x;
    logic [VW-1:0]     v_cnt, cell_y;
    logic [CPW-1:0]    px_cnt, py_cnt;
    logic [RBW-1:0]    row_base;
    logic [AFW-1:0]    addr_full;
    logic [AW-1:0]     s1_addr;
    logic [DATA_W-1:0] sdata;
    pix_ctl_t          ctl0;
    pix_ctl_t [2:1]    ctl_pipe;
    rgb_t              pix;

    assign pix_en      = (div_cnt == DW'(CLK_DIV - 1));
    assign div_next    = pix_en ? '0 : div_cnt + DW'(1);
    assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);
    assign addr_full   = AFW'(row_base) + AFW'(cell_x);

    assign ctl0 = '{act:  (int'(h_cnt) < H_ACT) && (int'(v_cnt) < V_ACT),
                    grid: (int'(cell_x) < CELLS_X) && (int'(cell_y) < CELLS_Y),
                    hs:   (int'(h_cnt) >= HS_BEG) && (int'(h_cnt) < HS_END),
                    vs:   (int'(v_cnt) >= VS_BEG) && (int'(v_cnt) < VS_END)};

    // Cell column/row and row base address step alongside h/v so the cell
    // address never needs a divide or multiply.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            vgaclk   <= 1'b0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            px_cnt   <= '0;
            py_cnt   <= '0;
            cell_x   <= '0;
            cell_y   <= '0;
            row_base <= '0;
            s1_addr  <= '0;
            ctl_pipe <= '0;
        end else begin
            div_cnt <= div_next;
            vgaclk  <= (div_next < DW'(CLK_DIV / 2));
            if (pix_en) begin
                s1_addr     <= AW'(addr_full);
                ctl_pipe[1] <= ctl0;
                ctl_pipe[2] <= ctl_pipe[1];
                if (h_cnt == HW'(H_TOTAL - 1)) begin
                    h_cnt  <= '0;
                    px_cnt <= '0;
                    cell_x <= '0;
                    if (v_cnt == VW'(V_TOTAL - 1)) begin
                        v_cnt    <= '0;
                        py_cnt   <= '0;
                        cell_y   <= '0;
                        row_base <= '0;
                    end else begin
                        v_cnt <= v_cnt + VW'(1);
                        if (py_cnt == CPW'(CELL_PX - 1)) begin
                            py_cnt   <= '0;
                            cell_y   <= cell_y + VW'(1);
                            row_base <= row_base + RBW'(CELLS_X);
                        end else begin
                            py_cnt <= py_cnt + CPW'(1);
                        end
                    end
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                    if (px_cnt == CPW'(CELL_PX - 1)) begin
                        px_cnt <= '0;
                        cell_x <= cell_x + HW'(1);
                    end else begin
                        px_cnt <= px_cnt + CPW'(1);
                    end
                end
            end
        end
    end

    video_ram_dp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata),
        .sen   (pix_en),
        .saddr (s1_addr),
        .sdata (sdata)
    );

    always_comb begin
        pix = '0;
        if (ctl_pipe[2].act)
            pix = ctl_pipe[2].grid ? expand332(8'(sdata)) : BORDER_RGB;
    end

    assign R     = pix.r;
    assign G     = pix.g;
    assign B     = pix.b;
    assign hsync = !ctl_pipe[2].hs;
    assign vsync = !ctl_pipe[2].vs;

endmodule

// File: tb/tb_vga_tile_display.sv
// Directed bench for vga_tile_display on a shrunken 32x24-pixel raster
// (4x4-pixel cells, 4x3 grid, 4 clks per pixel) so whole frames stay short.
module tb_vga_tile_display;

    localparam int CD = 4;
    localparam int HT = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we = 1'b0;
    logic [3:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [3:0] raddr = '0;
    logic [7:0] rdata, R, G, B;
    logic       hsync, vsync, vgaclk, frame_start;
    int         passes = 0;
    int         total = 0;

    always #5 clk = ~clk;

    vga_tile_display #(
        .DATA_W(8), .CELLS_X(4), .CELLS_Y(3), .CELL_PX(4), .CLK_DIV(CD),
        .H_ACT(24), .H_FP(2), .H_SYN(4), .H_BP(2),
        .V_ACT(20), .V_FP(1), .V_SYN(2), .V_BP(1),
        .BORDER(8'h6D)
    ) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .R(R), .G(G), .B(B),
        .hsync(hsync), .vsync(vsync), .vgaclk(vgaclk), .frame_start(frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 8000);
        chk("frame_seen", 32'(frame_start), 1);
    endtask

    // Pixel n is on the outputs during pixel period n+2 of its frame.
    task automatic pix(input string tag, input int h, input int v, input logic [25:0] exp);
        wait_frame();
        repeat (CD * (v * HT + h + 2) - (CD - 1)) @(posedge clk);
        #1;
        chk(tag, 32'({R, G, B, hsync, vsync}), 32'(exp));
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rgb"}, 32'({R, G, B}), 0);
        chk({tag, "_sync"}, 32'({hsync, vsync}), 32'b11);
        chk({tag, "_vgaclk"}, 32'(vgaclk), 0);
        chk({tag, "_fs"}, 32'(frame_start), 0);
        chk({tag, "_rdata"}, 32'(rdata), 0);
    endtask

    task automatic release_check(input string tag);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_fs_early"}, 32'(frame_start), 0);
        @(negedge clk);
        chk({tag, "_fs_first"}, 32'(frame_start), 1);
    endtask

    initial begin
        int n;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        release_check("rel");

        // CPU port: collision returns old data, then new data
        wr(4'd5, 8'h11);
        @(negedge clk);
        we = 1'b1; waddr = 4'd5; wdata = 8'h55; raddr = 4'd5;
        @(posedge clk); #1;
        chk("rw_old", 32'(rdata), 32'h11);
        @(negedge clk);
        we = 1'b0;
        @(posedge clk); #1;
        chk("rw_new", 32'(rdata), 32'h55);

        wr(4'd13, 8'hAA);
        @(negedge clk);
        raddr = 4'd13;
        @(posedge clk); #1;
        chk("oor_read", 32'(rdata), 0);

        wr(4'd0, 8'hE0);
        wr(4'd1, 8'h1C);
        wr(4'd5, 8'h03);
        wr(4'd11, 8'h92);
        @(negedge clk);
        raddr = 4'd0;
        @(posedge clk); #1;
        chk("rd_addr0", 32'(rdata), 32'hE0);

        pix("p00", 0, 0, {24'hFF0000, 2'b11});
        chk("vgaclk_hi", 32'(vgaclk), 1);
        repeat (2) @(posedge clk); #1;
        chk("vgaclk_lo", 32'(vgaclk), 0);
        pix("p33", 3, 3, {24'hFF0000, 2'b11});
        pix("p40", 4, 0, {24'h00FF00, 2'b11});
        pix("p55", 5, 5, {24'h0000FF, 2'b11});
        pix("p15_11", 15, 11, {24'h9292AA, 2'b11});
        pix("border_x", 17, 2, {24'h6D6D55, 2'b11});
        pix("border_y", 2, 13, {24'h6D6D55, 2'b11});
        pix("blank_h", 25, 2, {24'h000000, 2'b11});
        pix("hsync_lo", 27, 0, {24'h000000, 2'b01});
        pix("blank_v", 2, 20, {24'h000000, 2'b11});
        pix("vsync_lo", 2, 22, {24'h000000, 2'b10});

        wait_frame();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 5000);
        chk("frame_period", 32'(n), 3072);

        wait_frame();
        n = 0;
        for (int i = 0; i < CD * HT; i++) begin
            @(negedge clk);
            if (!hsync) n++;
        end
        chk("hsync_clks", 32'(n), 16);

        wait_frame();
        n = 0;
        for (int i = 0; i < 3072; i++) begin
            @(negedge clk);
            if (!vsync) n++;
        end
        chk("vsync_clks", 32'(n), 256);

        // Reset in the middle of line 10 aborts the frame; memory survives.
        wait_frame();
        repeat (CD * HT * 10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs("mid");
        repeat (3) @(negedge clk);
        release_check("mid_rel");
        pix("p00_kept", 0, 0, {24'hFF0000, 2'b11});

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/vga_tile_display.md
VGA_TILE_DISPLAY -- requirements
Module: vga_tile_display

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of one video cell in bits, colour format 3-3-2 RGB.
REQ-002 SHALL have parameter CELLS_X, default 8: cells per row.
REQ-003 SHALL have parameter CELLS_Y, default 8: cell rows; DEPTH = CELLS_X*CELLS_Y, AW = clog2(DEPTH).
REQ-004 SHALL have parameter CELL_PX, default 60: cell edge in pixels, square cells.
REQ-005 SHALL have parameter CLK_DIV, default 2: system clocks per pixel, must be >= 2.
REQ-006 SHALL have parameters H_ACT/H_FP/H_SYN/H_BP, defaults 640/16/96/48, and V_ACT/V_FP/V_SYN/V_BP, defaults 480/10/2/33.
REQ-007 SHALL have parameter BORDER, default 8'h00: colour for active pixels outside the cell grid.
REQ-008 clk, in, 1: single system clock, all logic on rising edge.
REQ-009 reset, in, 1: asynchronous, active-low reset.
REQ-010 we, in, 1: CPU write strobe, sampled each clk.
REQ-011 waddr, in, AW: CPU write address.
REQ-012 wdata, in, DATA_W: CPU write data.
REQ-013 raddr, in, AW: CPU read address.
REQ-014 rdata, out, DATA_W: CPU read data.
REQ-015 R, G, B, out, 8 each: pixel colour.
REQ-016 hsync, vsync, out, 1 each: active-low sync pulses.
REQ-017 vgaclk, out, 1: pixel clock, high for the first CLK_DIV/2 clks of each pixel period.
REQ-018 frame_start, out, 1: one-clk pulse at pixel (0,0) of each frame.

Function
REQ-019 Writes SHALL complete in one clk; waddr >= DEPTH SHALL be ignored.
REQ-020 rdata SHALL present mem[raddr] one clk after raddr is sampled; raddr >= DEPTH SHALL return 0.
REQ-021 Same-clk write and read of one address SHALL return the old data on both the CPU and scanout ports.
REQ-022 A divider SHALL produce pix_en once every CLK_DIV clks; h_cnt/v_cnt SHALL advance only on pix_en.
REQ-023 h_cnt SHALL wrap at H_TOTAL-1 to 0 and increment v_cnt; v_cnt SHALL wrap at V_TOTAL-1 to 0.
REQ-024 Scanout SHALL be a 2-stage pipeline (address compute, memory read); hsync, vsync and blank SHALL be delayed 2 pixel periods to stay aligned.
REQ-025 Cell address SHALL be (v_cnt/CELL_PX)*CELLS_X + h_cnt/CELL_PX, computed with incremental per-cell counters, no dividers.
REQ-026 Active pixels inside the grid SHALL show the cell colour: R={c[7:5],c[7:5],c[7:6]}, G={c[4:2],c[4:2],c[4:3]}, B={c[1:0] repeated 4x}.
REQ-027 Active pixels outside the grid SHALL show BORDER, expanded the same way; blanked pixels SHALL output 0.
REQ-028 hsync SHALL be low for h_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYN); vsync likewise in v.
REQ-029 frame_start SHALL pulse on the clk where pix_en is high and h_cnt=v_cnt=0, not pipeline-delayed.

Reset
REQ-030 While reset=0: counters, divider and pipeline SHALL be 0; R/G/B=0; hsync=vsync=1; vgaclk=0; frame_start=0; rdata=0.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 Reset asserted mid-frame SHALL abort the frame; the first post-reset pixel SHALL be (0,0).

Structure
REQ-033 Shared package vga_pkg SHALL hold the default timing constants, the 3-3-2 expansion function and the timing-parameter struct typedef.
REQ-034 The dual-port cell memory SHALL be one sub-module, video_ram_dp: synchronous write, two synchronous read ports.

Verification
REQ-035 Reset released, defaults -> frame_start period 800*525*2 = 840000 clks; hsync low for 192 clks per line.
REQ-036 Write 8'hE0 to addr 0 -> pixels (0..59, 0..59) R=FF G=00 B=00; pixel (60,0) shows addr 1.
REQ-037 Write addr 9 = 8'h03 -> pixel (65,65) B=FF R=G=00.
REQ-038 CELLS_X=4 -> pixel (300,10) shows BORDER; pixel (700,10) is blanked, R/G/B=0.
REQ-039 Same-clk we to addr 5 = 8'h55 with raddr=5 holding 8'h11 -> rdata=11; on the next read rdata=55.
REQ-040 Reset pulsed at v_cnt=200 -> outputs at reset values during reset; frame_start fires at the first pix_en after release.
